rx_token_decode: RTL

Receive-path token decoder sitting directly downstream of the receive character capture stage. Consumes captured data/control characters and their received/generated parity bits, and classifies each token as NULL, FCT, N-Char (data/EOP/EEP) or time-code. Detects parity, escape and credit errors, and drives the RX FIFO write port and link-FSM event flags.

---
 rtl/spw_rx_pkg.sv | 28 ++
 rtl/rx_credit_counter.sv | 45 ++++
 rtl/rx_token_decode.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spw_rx_pkg.sv
// Shared definitions for the receive-path token decoder: control codes,
// N-Char encodings written to the RX FIFO, decoder FSM states and the
// default credit configuration.
package spw_rx_pkg;

  localparam logic [2:0] CTRL_FCT = 3'b100;
  localparam logic [2:0] CTRL_EOP = 3'b101;
  localparam logic [2:0] CTRL_EEP = 3'b110;
  localparam logic [2:0] CTRL_ESC = 3'b111;

  localparam logic [8:0] NCHAR_EOP = 9'h100;
  localparam logic [8:0] NCHAR_EEP = 9'h101;

  localparam int DEF_CREDIT_STEP = 8;
  localparam int DEF_CREDIT_MAX  = 56;
  localparam int CREDIT_W        = 6;

  typedef enum logic {
    ST_IDLE,
    ST_ESC_PEND
  } rx_state_e;

  // A token fails parity whenever the received bit disagrees with the locally generated one.
  function automatic logic parity_bad(input logic rec, input logic gen);
    return rec != gen;
  endfunction

endpackage

// File: rtl/rx_credit_counter.sv
// Outstanding receive credit. Each FCT sent by the local transmitter grants
// CREDIT_STEP more characters, unless that would exceed CREDIT_MAX; each
// N-Char written to the FIFO consumes one. Never wraps below zero.
module rx_credit_counter
  import spw_rx_pkg::*;
#(
  parameter int CREDIT_STEP = DEF_CREDIT_STEP,
  parameter int CREDIT_MAX  = DEF_CREDIT_MAX
) (
  input  logic                posedge_clk,
  input  logic                rx_resetn,
  input  logic                inc,
  input  logic                dec,
  output logic [CREDIT_W-1:0] credit,
  output logic                zero
);

  localparam logic [CREDIT_W-1:0] STEP_V  = CREDIT_W'(CREDIT_STEP);
  localparam logic [CREDIT_W-1:0] LIMIT_V = CREDIT_W'(CREDIT_MAX - CREDIT_STEP);
  localparam logic [CREDIT_W-1:0] ONE_V   = CREDIT_W'(1);

  logic                inc_ok;
  logic [CREDIT_W-1:0] credit_n;

  // Next credit: the grant limit is judged on the value before this cycle's update.
  always_comb begin
    inc_ok   = inc && (credit <= LIMIT_V);
    credit_n = credit;
    case ({inc_ok, dec})
      2'b10:   credit_n = credit + STEP_V;
      2'b01:   if (credit != '0) credit_n = credit - ONE_V;
      2'b11:   credit_n = credit + STEP_V - ONE_V;
      default: credit_n = credit;
    endcase
  end

  // Credit register, cleared by reset.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) credit <= '0;
    else            credit <= credit_n;
  end

  assign zero = (credit == '0);

endmodule

// File: rtl/rx_token_decode.sv
// Receive-path token decoder. Classifies captured characters as NULL, FCT,
// N-Char or time-code, flags parity/escape/credit errors and drives the RX
// FIFO write port. All outputs are registered.
// Build option RX_CREDIT_CHECK_EN: when defined, a credit counter is present
// and N-Chars arriving with no credit are rejected; otherwise rx_credit and
// rx_error_credit are zero and fct_sent is ignored.
module rx_token_decode
  import spw_rx_pkg::*;
#(
  parameter int CREDIT_STEP = DEF_CREDIT_STEP,
  parameter int CREDIT_MAX  = DEF_CREDIT_MAX
) (
  input  logic                posedge_clk,
  input  logic                rx_resetn,
  input  logic                data_valid_p,
  input  logic                control_valid_p,
  input  logic [8:0]          dta_timec_p,
  input  logic                parity_rec_d,
  input  logic                parity_rec_d_gen,
  input  logic [2:0]          control_p_r,
  input  logic                parity_rec_c,
  input  logic                parity_rec_c_gen,
  input  logic                fct_sent,
  output logic                rx_got_null,
  output logic                rx_got_fct,
  output logic                rx_got_nchar,
  output logic                rx_got_time_code,
  output logic                rx_buffer_write,
  output logic [8:0]          rx_data_flag,
  output logic [7:0]          rx_time_out,
  output logic                rx_error_parity,
  output logic                rx_error_esc,
  output logic                rx_error_credit,
  output logic                rx_error,
  output logic [CREDIT_W-1:0] rx_credit
);

  rx_state_e  state;
  rx_state_e  state_n;
  logic       first_token;
  logic       any_valid;
  logic       parity_err;
  logic       nchar_req;
  logic [8:0] nchar_val;
  logic       do_write;
  logic       got_null_n;
  logic       got_fct_n;
  logic       got_tc_n;
  logic       err_par_n;
  logic       err_esc_n;
  logic       err_credit_n;
  logic [7:0] time_n;
  logic       credit_zero;
  logic       data_flag_unused;

  // The capture stage's data/control flag is implied by which valid pulse fires.
  assign data_flag_unused = dta_timec_p[8];

  // A control character wins when both valid pulses coincide; the data character is dropped.
  assign any_valid  = data_valid_p | control_valid_p;
  assign parity_err = !first_token &&
                      (control_valid_p ? parity_bad(parity_rec_c, parity_rec_c_gen)
                                       : parity_bad(parity_rec_d, parity_rec_d_gen));

`ifdef RX_CREDIT_CHECK_EN
  rx_credit_counter #(
    .CREDIT_STEP (CREDIT_STEP),
    .CREDIT_MAX  (CREDIT_MAX)
  ) u_credit (
    .posedge_clk (posedge_clk),
    .rx_resetn   (rx_resetn),
    .inc         (fct_sent),
    .dec         (do_write),
    .credit      (rx_credit),
    .zero        (credit_zero)
  );
`else
  localparam int credit_cfg_unused = CREDIT_STEP + CREDIT_MAX;
  logic fct_sent_unused;
  assign fct_sent_unused = fct_sent;
  assign rx_credit       = '0;
  assign credit_zero     = 1'b0;
`endif

  // Token classification: next FSM state and the events this token raises.
  always_comb begin
    state_n      = state;
    nchar_req    = 1'b0;
    nchar_val    = '0;
    got_null_n   = 1'b0;
    got_fct_n    = 1'b0;
    got_tc_n     = 1'b0;
    err_par_n    = 1'b0;
    err_esc_n    = 1'b0;
    time_n       = rx_time_out;
    if (any_valid) begin
      if (parity_err) begin
        err_par_n = 1'b1;
        state_n   = ST_IDLE;
      end else if (control_valid_p) begin
        case (state)
          ST_IDLE: begin
            case (control_p_r)
              CTRL_FCT: got_fct_n = 1'b1;
              CTRL_EOP: begin
                nchar_req = 1'b1;
                nchar_val = NCHAR_EOP;
              end
              CTRL_EEP: begin
                nchar_req = 1'b1;
                nchar_val = NCHAR_EEP;
              end
              CTRL_ESC: state_n = ST_ESC_PEND;
              default:  state_n = ST_IDLE;
            endcase
          end
          ST_ESC_PEND: begin
            state_n = ST_IDLE;
            if (control_p_r == CTRL_FCT) got_null_n = 1'b1;
            else                         err_esc_n  = 1'b1;
          end
          default: state_n = ST_IDLE;
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            nchar_req = 1'b1;
            nchar_val = {1'b0, dta_timec_p[7:0]};
          end
          ST_ESC_PEND: begin
            got_tc_n = 1'b1;
            time_n   = dta_timec_p[7:0];
            state_n  = ST_IDLE;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
    do_write     = nchar_req && !credit_zero;
    err_credit_n = nchar_req &&  credit_zero;
  end

  // FSM state and the first-token parity exemption.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state       <= ST_IDLE;
      first_token <= 1'b1;
    end else begin
      state <= state_n;
      if (any_valid) first_token <= 1'b0;
    end
  end

  // Registered event pulses, FIFO write port, held time-code and sticky error.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      rx_got_null      <= 1'b0;
      rx_got_fct       <= 1'b0;
      rx_got_nchar     <= 1'b0;
      rx_got_time_code <= 1'b0;
      rx_buffer_write  <= 1'b0;
      rx_data_flag     <= '0;
      rx_time_out      <= '0;
      rx_error_parity  <= 1'b0;
      rx_error_esc     <= 1'b0;
      rx_error_credit  <= 1'b0;
      rx_error         <= 1'b0;
    end else begin
      rx_got_null      <= got_null_n;
      rx_got_fct       <= got_fct_n;
      rx_got_nchar     <= do_write;
      rx_got_time_code <= got_tc_n;
      rx_buffer_write  <= do_write;
      if (do_write) rx_data_flag <= nchar_val;
      rx_time_out      <= time_n;
      rx_error_parity  <= err_par_n;
      rx_error_esc     <= err_esc_n;
      rx_error_credit  <= err_credit_n;
      rx_error         <= rx_error | err_par_n | err_esc_n | err_credit_n;
    end
  end

endmodule
